avalon_pio_in_edge: RTL and testbench
=====================================

Name: avalon_pio_in_edge

Overview:
- Parametrised Avalon-MM slave input port (PIO), successor to the fixed 4-bit level-only input PIO in the SoC.
- Synchronises an asynchronous input bus and exposes its level and per-bit edge capture to the Nios/HPS software over a 2-bit address space.
- Raises a maskable interrupt on a captured edge, so software no longer polls switch/handshake signals from the RSA datapath.

Parameters:
- WIDTH, 32: number of input bits (1..32); unused readdata bits read 0.
- EDGE_TYPE, 0: capture mode. 0 = rising, 1 = falling, 2 = any edge.
- SYNC_STAGES, 2: flip-flop stages on in_port (2..4).
- RESET_IRQMASK, 0: reset value of the interrupt mask register (WIDTH bits).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  2  word address: 0 = data, 1 = reserved, 2 = irqmask, 3 = edgecapture.
- chipselect  input  1  slave select.
- write  input  1  write strobe, qualified by chipselect.
- writedata  input  32  write data; bits [WIDTH-1:0] used.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  registered read data.
- irq  output  1  level interrupt, registered.

Behaviour:
- Reset (reset=1 at a clk edge) clears all of the following to 0: sync chain, prev-sample register, edgecapture, readdata, irq. irqmask takes RESET_IRQMASK. The warm-up counter loads SYNC_STAGES+1.
- Reset asserted mid-operation discards pending captures. No write is accepted while reset=1.
- Synchroniser: in_port passes through SYNC_STAGES flops to give sync_q. prev_q <= sync_q every cycle.
- Edge detect per bit i:
  - rise = sync_q[i] & ~prev_q[i]
  - fall = ~sync_q[i] & prev_q[i]
  - The mode selects rise, fall or rise|fall.
- Warm-up: detected edges are ignored while the warm-up counter is non-zero. The counter decrements once per cycle after reset, then saturates at 0. This prevents inputs that are high at reset release from producing spurious captures.
- edgecapture[i]:
  - Set on a detected edge.
  - Cleared by a write to address 3 with writedata[i]=1 (write-one-to-clear). writedata[i]=0 leaves the bit unchanged.
  - A set and a clear in the same cycle leave the bit at 1 (set wins).
- irqmask: a write to address 2 loads writedata[WIDTH-1:0].
- Writes to addresses 0 and 1 are ignored.
- readdata:
  - Registered every cycle from the address mux, regardless of chipselect. This gives read latency 1: the value for address A appears the cycle after A is presented.
  - Address 0 returns sync_q; address 1 returns 0; address 2 returns irqmask; address 3 returns edgecapture.
  - The mux uses current register contents, so a read of address 3 in the same cycle as a clear returns the pre-clear value.
  - Bits [31:WIDTH] are 0.
- irq <= |(edgecapture & irqmask), registered. It rises 1 cycle after the edgecapture bit sets and falls 1 cycle after the clear or mask write takes effect.
- End-to-end latency, from an in_port change to edgecapture set: SYNC_STAGES+1 cycles, with irq 1 cycle later.
- A pulse shorter than one clk period may be missed. This is not guaranteed captured.

Decomposition:
- Package avalon_pio_pkg holds:
  - address constants PIO_ADDR_DATA=0, PIO_ADDR_RSVD=1, PIO_ADDR_IRQMASK=2, PIO_ADDR_EDGECAP=3
  - enum edge_type_e {EDGE_RISE, EDGE_FALL, EDGE_ANY}
  - AVALON_DATA_W=32
- Sub-module pio_sync_chain(WIDTH, SYNC_STAGES): the parametrised synchroniser, with synchronous active-high reset.
- Edge detect, registers and the read mux stay in the top module.

Test Plan:
- Reset with in_port=32'hFFFF_FFFF held (WIDTH=32, EDGE_TYPE=0) -> after release, edgecapture reads 0 indefinitely and irq stays 0. Address 0 reads 32'hFFFF_FFFF after SYNC_STAGES+1 cycles.
- Rising edge on in_port[3] (0->1), irqmask=32'h8 -> edgecapture=32'h8 at cycle SYNC_STAGES+1 and irq=1 one cycle later. Writing 32'h8 to address 3 gives edgecapture=0 and irq=0 the following cycle.
- In the same cycle, a new edge on bit 3 and a write-1-to-clear of bit 3 -> edgecapture bit 3 remains 1 and irq stays 1.
- EDGE_TYPE=2, WIDTH=4: toggle in_port[0] 0->1->0 with 10 cycles between -> bit 0 set after each transition. With irqmask=0, irq stays 0; writing irqmask=4'h1 asserts irq 1 cycle later.
- Read address 1 and address 2 (WIDTH=8, irqmask written 32'hFFFF_FFA5) -> readdata=0 and 32'h0000_00A5 respectively, each 1 cycle after the address is presented.
- Assert reset for 1 cycle while edgecapture=32'h5 and irq=1 -> next cycle edgecapture=0, irq=0, readdata=0, irqmask=RESET_IRQMASK.

Source files
------------

// File: rtl/avalon_pio_pkg.sv
// Shared constants and types for the edge-capturing Avalon-MM input PIO.
// Word addresses, capture-mode encoding and the Avalon data width live here.
package avalon_pio_pkg;

    localparam int AVALON_DATA_W = 32;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

endpackage

// File: rtl/pio_sync_chain.sv
// Multi-flop synchroniser bringing the asynchronous input bus into the clk domain.
// Every stage clears on the synchronous reset so sync_q starts from a known 0.
module pio_sync_chain #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [SYNC_STAGES];

    // NOTE: this array is a handful of flops, not a RAM, so resetting every entry is legitimate.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/avalon_pio_in_edge.sv
// Avalon-MM input PIO: synchronised level read-back, per-bit edge capture (W1C)
// and a maskable, registered level interrupt.
module avalon_pio_in_edge
    import avalon_pio_pkg::*;
#(
    parameter int               WIDTH         = 32,
    parameter edge_type_e       EDGE_TYPE     = EDGE_RISE,
    parameter int               SYNC_STAGES   = 2,
    parameter logic [WIDTH-1:0] RESET_IRQMASK = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               address,
    input  logic                     chipselect,
    input  logic                     write,
    input  logic [AVALON_DATA_W-1:0] writedata,
    input  logic [WIDTH-1:0]         in_port,
    output logic [AVALON_DATA_W-1:0] readdata,
    output logic                     irq
);

    localparam int               WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]         sync_q;
    logic [WIDTH-1:0]         prev_q;
    logic [WIDTH-1:0]         edgecapture;
    logic [WIDTH-1:0]         irqmask;
    logic [WARM_W-1:0]        warm_cnt;
    logic [WIDTH-1:0]         edge_hit;
    logic [WIDTH-1:0]         edge_set;
    logic [WIDTH-1:0]         clr_mask;
    logic [AVALON_DATA_W-1:0] rd_mux;
    logic                     wr_en;
    logic                     unused_wr_bits;

    pio_sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in_port),
        .q     (sync_q)
    );

    assign wr_en          = chipselect & write;
    assign unused_wr_bits = ^writedata;

    // NOTE: assign every always_comb output before the case so no path leaves it unassigned (no latch).
    always_comb begin
        edge_hit = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edge_hit = sync_q & ~prev_q;
            EDGE_FALL: edge_hit = ~sync_q & prev_q;
            default:   edge_hit = (sync_q & ~prev_q) | (~sync_q & prev_q);
        endcase
    end

    // Chain contents are meaningless until it has refilled after reset.
    assign edge_set = (warm_cnt == '0) ? edge_hit : '0;
    assign clr_mask = (wr_en && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            PIO_ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_q;
            PIO_ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            PIO_ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecapture;
            default:          rd_mux = '0;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q      <= '0;
            edgecapture <= '0;
            irqmask     <= RESET_IRQMASK;
            warm_cnt    <= WARM_INIT;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            prev_q <= sync_q;
            if (warm_cnt != '0) begin
                warm_cnt <= warm_cnt - 1'b1;
            end
            if (wr_en && address == PIO_ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            // Set is OR-ed in after the clear, so a same-cycle edge wins.
            edgecapture <= (edgecapture & ~clr_mask) | edge_set;
            readdata    <= rd_mux;
            irq         <= |(edgecapture & irqmask);
        end
    end

endmodule

// File: tb/tb_avalon_pio_in_edge.sv
// Directed self-checking bench for avalon_pio_in_edge: three instances cover
// rising/32-bit, any-edge/4-bit and falling/8-bit configurations.
module tb_avalon_pio_in_edge;
    import avalon_pio_pkg::*;

    logic        clk = 1'b0;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        cs_a, cs_b, cs_c;
    logic        rst_a, rst_b, rst_c;
    logic [31:0] in_a;
    logic [3:0]  in_b;
    logic [7:0]  in_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;
    logic [31:0] r;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    avalon_pio_in_edge #(
        .WIDTH(32), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(2), .RESET_IRQMASK(32'h0000_0100)
    ) dut_a (
        .clk(clk), .reset(rst_a), .address(address), .chipselect(cs_a), .write(write),
        .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a)
    );

    avalon_pio_in_edge #(
        .WIDTH(4), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(3)
    ) dut_b (
        .clk(clk), .reset(rst_b), .address(address), .chipselect(cs_b), .write(write),
        .writedata(writedata), .in_port(in_b), .readdata(rd_b), .irq(irq_b)
    );

    avalon_pio_in_edge #(
        .WIDTH(8), .EDGE_TYPE(EDGE_FALL), .SYNC_STAGES(4)
    ) dut_c (
        .clk(clk), .reset(rst_c), .address(address), .chipselect(cs_c), .write(write),
        .writedata(writedata), .in_port(in_c), .readdata(rd_c), .irq(irq_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input int sel, input logic [1:0] addr, input logic [31:0] data);
        address   = addr;
        writedata = data;
        write     = 1'b1;
        cs_a      = (sel == 0);
        cs_b      = (sel == 1);
        cs_c      = (sel == 2);
        @(negedge clk);
        write = 1'b0;
        cs_a  = 1'b0;
        cs_b  = 1'b0;
        cs_c  = 1'b0;
    endtask

    task automatic read_reg(input int sel, input logic [1:0] addr, output logic [31:0] data);
        address = addr;
        write   = 1'b0;
        @(negedge clk);
        data = (sel == 0) ? rd_a : (sel == 1) ? rd_b : rd_c;
    endtask

    initial begin
        address = 2'd0; write = 1'b0; writedata = '0;
        cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        in_a = 32'hFFFF_FFFF; in_b = 4'h0; in_c = 8'hF0;
        tick(2);
        check("a_rst_readdata", rd_a, 32'h0);
        check("a_rst_irq", {31'b0, irq_a}, 32'h0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Inputs high through reset: level visible after S+1 cycles, no spurious capture.
        tick(2);
        check("a_data_early", rd_a, 32'h0);
        tick(1);
        check("a_data_level", rd_a, 32'hFFFF_FFFF);
        tick(10);
        read_reg(0, PIO_ADDR_EDGECAP, r);
        check("a_warm_edgecap", r, 32'h0);
        check("a_warm_irq", {31'b0, irq_a}, 32'h0);

        // Rising edge on bit 3, latency and W1C clear.
        in_a = 32'h0;
        tick(5);
        bus_write(0, PIO_ADDR_IRQMASK, 32'h8);
        read_reg(0, PIO_ADDR_EDGECAP, r);
        check("a_fall_ignored", r, 32'h0);
        in_a = 32'h8;
        tick(3);
        check("a_cap_early", rd_a, 32'h0);
        check("a_irq_early", {31'b0, irq_a}, 32'h0);
        tick(1);
        check("a_cap_lat", rd_a, 32'h8);
        check("a_irq_lat", {31'b0, irq_a}, 32'h1);
        bus_write(0, PIO_ADDR_EDGECAP, 32'h8);
        check("a_preclear_read", rd_a, 32'h8);
        check("a_preclear_irq", {31'b0, irq_a}, 32'h1);
        tick(1);
        check("a_cleared", rd_a, 32'h0);
        check("a_irq_cleared", {31'b0, irq_a}, 32'h0);

        // New edge and clear of the same bit in one cycle: set wins.
        in_a = 32'h0;
        tick(5);
        in_a = 32'h8;
        tick(2);
        bus_write(0, PIO_ADDR_EDGECAP, 32'h8);
        check("a_collide_pre", rd_a, 32'h0);
        tick(1);
        check("a_collide_set", rd_a, 32'h8);
        check("a_collide_irq", {31'b0, irq_a}, 32'h1);
        bus_write(0, PIO_ADDR_EDGECAP, 32'h7);
        tick(1);
        check("a_w0_keep", rd_a, 32'h8);
        bus_write(0, PIO_ADDR_EDGECAP, 32'h8);
        tick(1);

        // Mid-operation reset discards captures; a write during reset is dropped.
        bus_write(0, PIO_ADDR_IRQMASK, 32'h5);
        in_a = 32'hD;
        tick(5);
        read_reg(0, PIO_ADDR_EDGECAP, r);
        check("a_pre_rst_cap", r, 32'h5);
        check("a_pre_rst_irq", {31'b0, irq_a}, 32'h1);
        rst_a = 1'b1; address = PIO_ADDR_IRQMASK; writedata = 32'hFFFF_FFFF;
        write = 1'b1; cs_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; write = 1'b0; cs_a = 1'b0;
        check("a_mid_rst_irq", {31'b0, irq_a}, 32'h0);
        check("a_mid_rst_rd", rd_a, 32'h0);
        read_reg(0, PIO_ADDR_IRQMASK, r);
        check("a_rst_irqmask", r, 32'h0000_0100);
        tick(8);
        read_reg(0, PIO_ADDR_EDGECAP, r);
        check("a_rst_edgecap", r, 32'h0);
        check("a_rst_irq_stay", {31'b0, irq_a}, 32'h0);

        // Any-edge mode, 4 bits wide.
        in_b = 4'h1;
        tick(10);
        read_reg(1, PIO_ADDR_EDGECAP, r);
        check("b_rise", r, 32'h1);
        bus_write(1, PIO_ADDR_EDGECAP, 32'h1);
        read_reg(1, PIO_ADDR_EDGECAP, r);
        check("b_clear", r, 32'h0);
        in_b = 4'h0;
        tick(10);
        read_reg(1, PIO_ADDR_EDGECAP, r);
        check("b_fall", r, 32'h1);
        check("b_irq_masked", {31'b0, irq_b}, 32'h0);
        bus_write(1, PIO_ADDR_IRQMASK, 32'h1);
        check("b_irq_pre", {31'b0, irq_b}, 32'h0);
        tick(1);
        check("b_irq_post", {31'b0, irq_b}, 32'h1);
        bus_write(1, PIO_ADDR_IRQMASK, 32'hFFFF_FFFF);
        read_reg(1, PIO_ADDR_IRQMASK, r);
        check("b_mask_width", r, 32'h0000_000F);
        in_b = 4'hF;
        tick(6);
        read_reg(1, PIO_ADDR_DATA, r);
        check("b_data_width", r, 32'h0000_000F);

        // Falling mode, 8 bits wide, reserved address and read-only writes.
        bus_write(2, PIO_ADDR_IRQMASK, 32'hFFFF_FFA5);
        read_reg(2, PIO_ADDR_RSVD, r);
        check("c_rsvd", r, 32'h0);
        read_reg(2, PIO_ADDR_IRQMASK, r);
        check("c_irqmask", r, 32'h0000_00A5);
        in_c = 8'h30;
        tick(10);
        read_reg(2, PIO_ADDR_EDGECAP, r);
        check("c_fall", r, 32'h0000_00C0);
        check("c_irq", {31'b0, irq_c}, 32'h1);
        in_c = 8'h33;
        tick(10);
        read_reg(2, PIO_ADDR_EDGECAP, r);
        check("c_rise_ignored", r, 32'h0000_00C0);
        bus_write(2, PIO_ADDR_DATA, 32'hFFFF_FFFF);
        bus_write(2, PIO_ADDR_RSVD, 32'hFFFF_FFFF);
        read_reg(2, PIO_ADDR_IRQMASK, r);
        check("c_ro_writes", r, 32'h0000_00A5);
        read_reg(2, PIO_ADDR_DATA, r);
        check("c_data", r, 32'h0000_0033);
        bus_write(2, PIO_ADDR_EDGECAP, 32'h80);
        read_reg(2, PIO_ADDR_EDGECAP, r);
        check("c_partial_clear", r, 32'h0000_0040);
        check("c_irq_unmasked_left", {31'b0, irq_c}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
